// File: rtl/spi_reg_bank_pkg.sv
// Shared register-map constants for the SPI register bank.
// Firmware header generation and the bench both draw from this one source.
package spi_regs_pkg;

  localparam int unsigned ADDR_ID        = 'h00;
  localparam int unsigned ADDR_SCRATCH   = 'h01;
  localparam int unsigned ADDR_FLAGS     = 'h02;
  localparam int unsigned ADDR_IE        = 'h03;
  localparam int unsigned ADDR_PULSE     = 'h04;
  localparam int unsigned ADDR_CTRL_BASE = 'h10;

  localparam logic [31:0] ID_VALUE = 32'h1C0A_0001;

endpackage

// File: rtl/spi_reg_bank_if.sv
// Synchronous address/data/strobe bus between the SPI slave front end
// (master side) and the register bank (slave side).
interface spi_reg_bank_if #(
  parameter int ASZ = 7,
  parameter int DSZ = 32
);
  logic [ASZ-1:0] addr;
  logic [DSZ-1:0] wdata;
  logic           wr_en;
  logic           rd_en;
  logic [DSZ-1:0] rdata;

  modport master (output addr, output wdata, output wr_en, output rd_en, input rdata);
  modport slave  (input addr, input wdata, input wr_en, input rd_en, output rdata);
endinterface

// File: rtl/spi_reg_bank.sv
// Register bank behind the SPI slave front end: ID, scratch, sticky event
// flags with interrupt enable, one-shot command pulses and control registers.
module spi_reg_bank
  import spi_regs_pkg::*;
#(
  parameter int              ASZ      = 7,
  parameter int              DSZ      = 32,
  parameter int              CTRL_N   = 8,
  parameter logic [DSZ-1:0]  ID_VALUE = DSZ'(spi_regs_pkg::ID_VALUE)
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_reg_bank_if.slave         bus,
  output logic [CTRL_N*DSZ-1:0] ctrl,
  input  logic [DSZ-1:0]        evt,
  output logic [DSZ-1:0]        pulse,
  output logic                  irq
);

  logic [DSZ-1:0] scratch_q;
  logic [DSZ-1:0] flags_q;
  logic [DSZ-1:0] ie_q;
  logic [DSZ-1:0] ctrl_q [CTRL_N];
  logic [DSZ-1:0] rd_mux;
  logic [DSZ-1:0] flags_clr;

  logic wr_scratch, wr_flags, wr_ie, wr_pulse;

  assign wr_scratch = bus.wr_en && (bus.addr == ASZ'(ADDR_SCRATCH));
  assign wr_flags   = bus.wr_en && (bus.addr == ASZ'(ADDR_FLAGS));
  assign wr_ie      = bus.wr_en && (bus.addr == ASZ'(ADDR_IE));
  assign wr_pulse   = bus.wr_en && (bus.addr == ASZ'(ADDR_PULSE));
  assign flags_clr  = wr_flags ? bus.wdata : '0;

  for (genvar g = 0; g < CTRL_N; g++) begin : g_ctrl_flat
    assign ctrl[g*DSZ +: DSZ] = ctrl_q[g];
  end

  always_comb begin
    rd_mux = '0;
    if (bus.addr == ASZ'(ADDR_ID))      rd_mux = ID_VALUE;
    if (bus.addr == ASZ'(ADDR_SCRATCH)) rd_mux = scratch_q;
    if (bus.addr == ASZ'(ADDR_FLAGS))   rd_mux = flags_q;
    if (bus.addr == ASZ'(ADDR_IE))      rd_mux = ie_q;
    for (int i = 0; i < CTRL_N; i++) begin
      if (bus.addr == ASZ'(ADDR_CTRL_BASE + i)) rd_mux = ctrl_q[i];
    end
  end

  // Read data holds between read strobes; a simultaneous write sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rdata <= '0;
    end else if (bus.rd_en) begin
      bus.rdata <= rd_mux;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scratch_q <= '0;
      ie_q      <= '0;
      for (int i = 0; i < CTRL_N; i++) ctrl_q[i] <= '0;
    end else begin
      if (wr_scratch) scratch_q <= bus.wdata;
      if (wr_ie)      ie_q      <= bus.wdata;
      for (int i = 0; i < CTRL_N; i++) begin
        if (bus.wr_en && (bus.addr == ASZ'(ADDR_CTRL_BASE + i))) ctrl_q[i] <= bus.wdata;
      end
    end
  end

  // Event set takes priority over W1C clear on the same bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
      pulse   <= '0;
      irq     <= 1'b0;
    end else begin
      flags_q <= (flags_q & ~flags_clr) | evt;
      pulse   <= wr_pulse ? bus.wdata : '0;
      irq     <= |(flags_q & ie_q);
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: reads are scored against a queue of
// expected values filled from a small register model when the strobe is driven.
module tb_spi_reg_bank;
  import spi_regs_pkg::*;

  localparam int ASZ    = 7;
  localparam int DSZ    = 32;
  localparam int CTRL_N = 8;

  logic                  clk;
  logic                  rst;
  logic [CTRL_N*DSZ-1:0] ctrl;
  logic [DSZ-1:0]        evt;
  logic [DSZ-1:0]        pulse;
  logic                  irq;

  spi_reg_bank_if #(.ASZ(ASZ), .DSZ(DSZ)) bus ();

  spi_reg_bank #(.ASZ(ASZ), .DSZ(DSZ), .CTRL_N(CTRL_N)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .ctrl  (ctrl),
    .evt   (evt),
    .pulse (pulse),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] exp_q [$];
  logic [31:0] m_scratch, m_flags, m_ie;
  logic [31:0] m_ctrl [CTRL_N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_scratch = '0; m_flags = '0; m_ie = '0;
    for (int i = 0; i < CTRL_N; i++) m_ctrl[i] = '0;
  endtask

  function automatic logic [31:0] model_rd(input int unsigned a);
    logic [31:0] r;
    r = '0;
    if (a == ADDR_ID)      r = 32'h1C0A_0001;
    if (a == ADDR_SCRATCH) r = m_scratch;
    if (a == ADDR_FLAGS)   r = m_flags;
    if (a == ADDR_IE)      r = m_ie;
    if (a >= ADDR_CTRL_BASE && a < ADDR_CTRL_BASE + CTRL_N) r = m_ctrl[a - ADDR_CTRL_BASE];
    return r;
  endfunction

  task automatic model_wr(input int unsigned a, input logic [31:0] d);
    if (a == ADDR_SCRATCH) m_scratch = d;
    if (a == ADDR_FLAGS)   m_flags   = m_flags & ~d;
    if (a == ADDR_IE)      m_ie      = d;
    if (a >= ADDR_CTRL_BASE && a < ADDR_CTRL_BASE + CTRL_N) m_ctrl[a - ADDR_CTRL_BASE] = d;
  endtask

  task automatic do_write(input int unsigned a, input logic [31:0] d);
    @(negedge clk);
    bus.addr = ASZ'(a); bus.wdata = d; bus.wr_en = 1'b1;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    model_wr(a, d);
  endtask

  task automatic do_read(input string tag, input int unsigned a);
    logic [31:0] e;
    @(negedge clk);
    bus.addr = ASZ'(a); bus.rd_en = 1'b1;
    exp_q.push_back(model_rd(a));
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    e = exp_q.pop_front();
    chk(tag, bus.rdata, e);
  endtask

  task automatic pulse_evt(input logic [31:0] v);
    @(negedge clk);
    evt = v;
    @(posedge clk); #1;
    evt = '0;
    m_flags = m_flags | v;
  endtask

  task automatic chk_ctrl(input string tag);
    for (int i = 0; i < CTRL_N; i++)
      chk($sformatf("%s_ctrl%0d", tag, i), ctrl[i*DSZ +: DSZ], m_ctrl[i]);
  endtask

  initial begin
    logic [31:0] held;
    rst = 1'b1; evt = '0;
    bus.addr = '0; bus.wdata = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    model_reset();
    #2;
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_pulse", pulse, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    do_read("rd_id", ADDR_ID);
    do_read("rd_scratch0", ADDR_SCRATCH);
    chk_ctrl("init");
    chk("init_irq", {31'b0, irq}, 32'h0);

    // Control register write and readback; unmapped and RO writes ignored.
    do_write(ADDR_CTRL_BASE + 3, 32'hA5A5_0F0F);
    chk_ctrl("wr13");
    do_read("rd_ctrl3", ADDR_CTRL_BASE + 3);
    held = bus.rdata;
    do_write(ADDR_CTRL_BASE + 7, 32'hDEAD_BEEF);
    chk("rdata_hold_on_wr", bus.rdata, held);
    do_write('h7F, 32'hFFFF_FFFF);
    do_write(ADDR_ID, 32'h0);
    do_read("rd_unmapped", 'h7F);
    do_read("rd_id_after_wr", ADDR_ID);
    do_read("rd_ctrl7", ADDR_CTRL_BASE + 7);
    chk_ctrl("after_unmapped");

    // Flags, enable and interrupt.
    pulse_evt(32'h20);
    do_read("rd_flags_set", ADDR_FLAGS);
    chk("irq_masked", {31'b0, irq}, 32'h0);
    do_write(ADDR_IE, 32'h20);
    @(posedge clk); #1;
    chk("irq_on", {31'b0, irq}, 32'h1);
    do_write(ADDR_FLAGS, 32'h20);
    @(posedge clk); #1;
    chk("irq_off", {31'b0, irq}, 32'h0);
    do_read("rd_flags_clr", ADDR_FLAGS);

    // Set and clear on the same bit in the same cycle: set wins.
    @(negedge clk);
    bus.addr = ASZ'(ADDR_FLAGS); bus.wdata = 32'h20; bus.wr_en = 1'b1; evt = 32'h20;
    @(posedge clk); #1;
    bus.wr_en = 1'b0; evt = '0;
    m_flags = (m_flags & ~32'h20) | 32'h20;
    do_read("rd_flags_race", ADDR_FLAGS);

    // Simultaneous read and write returns the pre-write value.
    do_write(ADDR_SCRATCH, 32'h0BAD_F00D);
    @(negedge clk);
    bus.addr = ASZ'(ADDR_SCRATCH); bus.wdata = 32'h1111_2222;
    bus.wr_en = 1'b1; bus.rd_en = 1'b1;
    exp_q.push_back(model_rd(ADDR_SCRATCH));
    @(posedge clk); #1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    chk("rdwr_same_cycle", bus.rdata, exp_q.pop_front());
    model_wr(ADDR_SCRATCH, 32'h1111_2222);
    do_read("rd_scratch_new", ADDR_SCRATCH);

    // Pulse lasts exactly one cycle; back-to-back writes give back-to-back pulses.
    do_write(ADDR_PULSE, 32'h3);
    chk("pulse_on", pulse, 32'h3);
    @(posedge clk); #1;
    chk("pulse_off", pulse, 32'h0);
    do_write(ADDR_PULSE, 32'h5);
    chk("pulse_b2b_a", pulse, 32'h5);
    @(negedge clk);
    bus.addr = ASZ'(ADDR_PULSE); bus.wdata = 32'h9; bus.wr_en = 1'b1;
    @(posedge clk); #1;
    chk("pulse_b2b_a1", pulse, 32'h9);
    @(negedge clk);
    bus.wdata = 32'hC; bus.wr_en = 1'b1;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    chk("pulse_b2b_b", pulse, 32'hC);
    do_read("rd_pulse", ADDR_PULSE);

    // Asynchronous reset mid-cycle with a pulse in flight.
    do_write(ADDR_SCRATCH, 32'h1234_5678);
    do_read("rd_ctrl3_pre_rst", ADDR_CTRL_BASE + 3);
    do_write(ADDR_PULSE, 32'h3);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_pulse", pulse, 32'h0);
    chk("arst_rdata", bus.rdata, 32'h0);
    chk("arst_irq", {31'b0, irq}, 32'h0);
    chk_ctrl("arst");
    @(negedge clk);
    rst = 1'b0;
    do_read("rd_scratch_post_rst", ADDR_SCRATCH);
    do_read("rd_flags_post_rst", ADDR_FLAGS);
    do_read("rd_ie_post_rst", ADDR_IE);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
